// File: rtl/maxnet_operand_sequencer_if.sv
// Operand-in and result-out valid/ready channels of the Maxnet operand sequencer.
interface maxnet_operand_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_err;

   modport master (
      output in_valid, in_data, res_ready,
      input  in_ready, res_valid, res_data, res_err
   );

   modport slave (
      input  in_valid, in_data, res_ready,
      output in_ready, res_valid, res_data, res_err
   );
endinterface

// File: rtl/maxnet_operand_sequencer.sv
// Collects eps,a1..a4 for the Maxnet core, pulses start, waits for finish and returns the result.
// Optional NEG_CLAMP_EN: negative (non-NaN) activations a1..a4 are stored as +0.
module maxnet_operand_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_W          = 11
) (
   input  logic                      clk,
   input  logic                      rst,
   maxnet_operand_sequencer_if.slave bus,
   output logic                      mx_start,
   output logic [31:0]               mx_eps,
   output logic [31:0]               mx_a1,
   output logic [31:0]               mx_a2,
   output logic [31:0]               mx_a3,
   output logic [31:0]               mx_a4,
   input  logic                      mx_finish,
   input  logic [31:0]               mx_out
);
   localparam int unsigned W       = 32;
   localparam int unsigned N_OPS   = 5;
   localparam int unsigned IDX_W   = 3;
   localparam logic [W-1:0] QNAN   = 32'h7FC0_0000;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {LOAD, START, WAIT, RESULT} state_e;

   state_e                      state_q, state_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        nan_seen_q, nan_seen_d;
   logic                        start_q, start_d;
   logic [N_OPS-1:0][W-1:0]     ops_q, ops_d;
   logic                        res_valid_q, res_valid_d;
   logic [W-1:0]                res_data_q, res_data_d;
   logic                        res_err_q, res_err_d;

   logic                        accept_c;
   logic                        word_nan_c;
   logic [W-1:0]                word_c;

   // NaN detection and optional clamp of the incoming word
   always_comb begin : word_classify
      word_nan_c = (bus.in_data[30:23] == 8'hFF) && (bus.in_data[22:0] != 23'd0);
      word_c     = bus.in_data;
`ifdef NEG_CLAMP_EN
      if ((idx_q != IDX_W'(0)) && bus.in_data[31] && !word_nan_c) begin
         word_c = '0;
      end
`endif
   end

   assign accept_c = bus.in_valid && (state_q == LOAD);

   always_comb begin : next_state
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      nan_seen_d  = nan_seen_q;
      ops_d       = ops_q;
      start_d     = 1'b0;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_err_d   = res_err_q;

      unique case (state_q)
         LOAD: begin
            if (accept_c) begin
               ops_d[idx_q] = word_c;
               nan_seen_d   = nan_seen_q | word_nan_c;
               if (idx_q == IDX_W'(N_OPS - 1)) begin
                  idx_d = '0;
                  // A NaN operand skips the core entirely
                  if (nan_seen_d) begin
                     state_d     = RESULT;
                     res_valid_d = 1'b1;
                     res_data_d  = QNAN;
                     res_err_d   = 1'b1;
                  end else begin
                     state_d = START;
                     start_d = 1'b1;
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         START: state_d = WAIT;
         WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mx_finish) begin
               state_d     = RESULT;
               res_valid_d = 1'b1;
               res_data_d  = mx_out;
               res_err_d   = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = RESULT;
               res_valid_d = 1'b1;
               res_data_d  = QNAN;
               res_err_d   = 1'b1;
            end
         end
         RESULT: begin
            if (bus.res_ready) begin
               state_d     = LOAD;
               res_valid_d = 1'b0;
               cnt_d       = '0;
               nan_seen_d  = 1'b0;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin : state_reg
      if (rst) begin
         state_q     <= LOAD;
         idx_q       <= '0;
         cnt_q       <= '0;
         nan_seen_q  <= 1'b0;
         start_q     <= 1'b0;
         ops_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         nan_seen_q  <= nan_seen_d;
         start_q     <= start_d;
         ops_q       <= ops_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_err_q   <= res_err_d;
      end
   end

   // Ready is a state decode so it is already high in the first LOAD cycle after reset
   assign bus.in_ready  = (state_q == LOAD) && !rst;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_err   = res_err_q;
   assign mx_start      = start_q;
   assign mx_eps        = ops_q[0];
   assign mx_a1         = ops_q[1];
   assign mx_a2         = ops_q[2];
   assign mx_a3         = ops_q[3];
   assign mx_a4         = ops_q[4];
endmodule
